multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 21 ++
 rtl/mul_div_core.sv | 91 +++++++++
 rtl/multicycle_alu.sv | 133 +++++++++++++
 tb/tb_multicycle_alu.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state type for the multicycle ALU.
// The divider is present only when MULTICYCLE_ALU_DIV_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_PASSA = 4'b0000;
    localparam logic [3:0] OP_NOTA  = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/mul_div_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per step.
// The divider half exists only when MULTICYCLE_ALU_DIV_EN is defined.
module mul_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] lo_nxt,
    output logic [WIDTH-1:0] hi_nxt
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] bd;
    logic [WIDTH:0]   sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));

    // acc holds the running high half (MUL) or partial remainder (DIVU); mq the low half / quotient
    always_ff @(posedge clk) begin
        if (load) begin
            acc <= '0;
            mq  <= a;
            bd  <= b;
        end else if (step) begin
            acc <= hi_nxt;
            mq  <= lo_nxt;
        end
    end

    assign sum = {1'b0, acc} + {1'b0, (mq[0] ? bd : {WIDTH{1'b0}})};

`ifdef MULTICYCLE_ALU_DIV_EN
    logic           div_q;
    logic [WIDTH:0] shf;
    logic [WIDTH:0] dif;
    logic [WIDTH:0] rem_w;
    logic           ge;
    logic           unused_rem_top;

    always_ff @(posedge clk) begin
        if (load) begin
            div_q <= is_div;
        end
    end

    // b=0 never fails the compare, giving all-ones quotient and remainder = a
    assign shf   = {acc, mq[WIDTH-1]};
    assign ge    = (shf >= {1'b0, bd});
    assign dif   = shf - {1'b0, bd};
    assign rem_w = ge ? dif : shf;
    assign unused_rem_top = rem_w[WIDTH];

    always_comb begin
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], mq[WIDTH-1:1]};
        if (div_q) begin
            hi_nxt = rem_w[WIDTH-1:0];
            lo_nxt = {mq[WIDTH-2:0], ge};
        end
    end
`else
    logic unused_is_div;
    assign unused_is_div = is_div;

    always_comb begin
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], mq[WIDTH-1:1]};
    end
`endif

endmodule

// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative MUL and optional DIVU.
// Define MULTICYCLE_ALU_DIV_EN to build the divider; otherwise opcode 1001 is illegal.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal
);

    import alu_pkg::*;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             multi;
    logic             ill;
    logic             last;
    logic             eq_q;
    logic [WIDTH-1:0] simple_res;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH-1:0] hi_nxt;

    function automatic logic slt(input logic signed [WIDTH-1:0] x,
                                 input logic signed [WIDTH-1:0] y);
        return x < y;
    endfunction

    always_comb begin
        multi      = 1'b0;
        ill        = 1'b0;
        simple_res = '0;
        case (op)
            OP_PASSA: simple_res = a;
            OP_NOTA:  simple_res = ~a;
            OP_ADD:   simple_res = a + b;
            OP_SUB:   simple_res = a - b;
            OP_OR:    simple_res = a | b;
            OP_AND:   simple_res = a & b;
            OP_SLT:   simple_res = {{(WIDTH-1){1'b0}}, slt(a, b)};
            OP_MUL:   multi = 1'b1;
`ifdef MULTICYCLE_ALU_DIV_EN
            OP_DIVU:  multi = 1'b1;
`endif
            default:  ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIN accepts a new start just like IDLE, allowing back-to-back operations
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE, S_FIN: begin
                done = (state == S_FIN);
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = multi ? S_RUN : S_FIN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = S_FIN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            eq_q <= (a == b);
        end
    end

    mul_div_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (accept && multi),
        .step   (state == S_RUN),
        .is_div (op == OP_DIVU),
        .a      (a),
        .b      (b),
        .last   (last),
        .lo_nxt (lo_nxt),
        .hi_nxt (hi_nxt)
    );

    // Outputs change only on the edge that enters FIN and hold until the next completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !multi) begin
            result    <= ill ? '0 : simple_res;
            result_hi <= '0;
            zero      <= (a == b);
            illegal   <= ill;
        end else if ((state == S_RUN) && last) begin
            result    <= lo_nxt;
            result_hi <= hi_nxt;
            zero      <= eq_q;
            illegal   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH=32.
// Expectations for DIVU follow MULTICYCLE_ALU_DIV_EN as the design does.
module tb_multicycle_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op = 4'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  result;
    logic [W-1:0]  result_hi;
    logic          zero;
    logic          busy;
    logic          done;
    logic          illegal;

    int total = 0;
    int bad   = 0;

    multicycle_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Drive start for one accepting edge; returns at 1 time unit after that edge
    task automatic launch(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int lat0, output int lat, output bit busy_seen);
        lat       = lat0;
        busy_seen = busy;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            busy_seen |= busy;
        end
        if (!done) chk("done_timeout", 64'(done), 64'd1);
    endtask

    int lat;
    bit bs;
    bit done_seen;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_hi", 64'(result_hi), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD wraps
        launch(4'b0010, 32'hFFFF_FFFF, 32'd1);
        wait_done(1, lat, bs);
        chk("add_lat", 64'(lat), 64'd1);
        chk("add_result", 64'(result), 64'd0);
        chk("add_zero", 64'(zero), 64'd0);
        chk("add_busy", 64'(bs), 64'd0);
        chk("add_hi", 64'(result_hi), 64'd0);

        // MUL with an ignored start pulse in the middle of RUN
        launch(4'b1000, 32'hFFFF_FFFF, 32'd2);
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("mul_busy_mid", 64'(busy), 64'd1);
        op = 4'b0010; a = 32'd3; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        wait_done(lat, lat, bs);
        chk("mul_lat", 64'(lat), 64'd33);
        chk("mul_lo", 64'(result), 64'hFFFF_FFFE);
        chk("mul_hi", 64'(result_hi), 64'd1);
        chk("mul_zero", 64'(zero), 64'd0);
        @(posedge clk);
        #1;
        chk("mul_done_pulse", 64'(done), 64'd0);
        chk("mul_hold", 64'(result), 64'hFFFF_FFFE);

        // small MUL
        launch(4'b1000, 32'd12345, 32'd678);
        wait_done(1, lat, bs);
        chk("mul2_lo", 64'(result), 64'd8369910);
        chk("mul2_hi", 64'(result_hi), 64'd0);

`ifdef MULTICYCLE_ALU_DIV_EN
        launch(4'b1001, 32'd100, 32'd7);
        wait_done(1, lat, bs);
        chk("div_lat", 64'(lat), 64'd33);
        chk("div_q", 64'(result), 64'd14);
        chk("div_r", 64'(result_hi), 64'd2);
        chk("div_illegal", 64'(illegal), 64'd0);
        launch(4'b1001, 32'd5, 32'd0);
        wait_done(1, lat, bs);
        chk("div0_lat", 64'(lat), 64'd33);
        chk("div0_q", 64'(result), 64'hFFFF_FFFF);
        chk("div0_r", 64'(result_hi), 64'd5);
`else
        launch(4'b1001, 32'd100, 32'd7);
        wait_done(1, lat, bs);
        chk("div_lat", 64'(lat), 64'd1);
        chk("div_illegal", 64'(illegal), 64'd1);
        chk("div_result", 64'(result), 64'd0);
        chk("div_hi", 64'(result_hi), 64'd0);
`endif

        // SLT signed
        launch(4'b0111, 32'h8000_0000, 32'd1);
        wait_done(1, lat, bs);
        chk("slt_result", 64'(result), 64'd1);
        chk("slt_illegal", 64'(illegal), 64'd0);
        launch(4'b0111, 32'd1, 32'h8000_0000);
        wait_done(1, lat, bs);
        chk("slt_rev", 64'(result), 64'd0);

        // illegal opcode, then a legal op clears the flag
        launch(4'b0110, 32'd7, 32'd3);
        wait_done(1, lat, bs);
        chk("ill_lat", 64'(lat), 64'd1);
        chk("ill_flag", 64'(illegal), 64'd1);
        chk("ill_result", 64'(result), 64'd0);
        launch(4'b0011, 32'd9, 32'd9);
        wait_done(1, lat, bs);
        chk("sub_result", 64'(result), 64'd0);
        chk("sub_zero", 64'(zero), 64'd1);
        chk("sub_illegal", 64'(illegal), 64'd0);

        // remaining simple ops
        launch(4'b0001, 32'h0F0F_00FF, 32'd0);
        wait_done(1, lat, bs);
        chk("nota", 64'(result), 64'hF0F0_FF00);
        launch(4'b0100, 32'hA000_0005, 32'h0500_0050);
        wait_done(1, lat, bs);
        chk("or", 64'(result), 64'hA500_0055);
        launch(4'b0101, 32'hFF00_FF00, 32'h0FF0_0FF0);
        wait_done(1, lat, bs);
        chk("and", 64'(result), 64'h0F00_0F00);
        launch(4'b0000, 32'h1234_5678, 32'd0);
        wait_done(1, lat, bs);
        chk("passa", 64'(result), 64'h1234_5678);

        // reset at RUN cycle 10 of a MUL
        launch(4'b1000, 32'd5, 32'd6);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
        end
        chk("rstrun_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("rstrun_busy", 64'(busy), 64'd0);
        chk("rstrun_done", 64'(done), 64'd0);
        chk("rstrun_result", 64'(result), 64'd0);
        chk("rstrun_hi", 64'(result_hi), 64'd0);
        chk("rstrun_zero", 64'(zero), 64'd0);
        chk("rstrun_illegal", 64'(illegal), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            done_seen |= done;
        end
        chk("rstrun_no_done", 64'(done_seen), 64'd0);

        // back-to-back: start held through FIN
        @(negedge clk);
        op = 4'b0010; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_done1", 64'(done), 64'd1);
        chk("b2b_res1", 64'(result), 64'd5);
        op = 4'b0011; a = 32'd10; b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_done2", 64'(done), 64'd1);
        chk("b2b_res2", 64'(result), 64'd6);
        @(posedge clk);
        #1;
        chk("b2b_idle", 64'(done), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
